// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module   : imem_loader
// Purpose  : Program loader for the instruction memory write port. Packs a
//            little-endian byte stream (valid/ready) into INST_WIDTH words,
//            writes them at consecutive addresses from 0 and holds the fetch
//            stage while a load is running.
// Options  : LOADER_CSUM_EN - when defined, one extra word is accepted after
//            the program and compared against the XOR of all written words.
// Revision : 1.0 - initial release
// ============================================================================
module imem_loader #(
  parameter int INST_WIDTH = 32,
  parameter int MEM_SIZE   = 16,
  localparam int c_AW      = $clog2(MEM_SIZE)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_start,
  input  logic [c_AW:0]         i_num_words,
  input  logic                  i_byte_valid,
  input  logic [7:0]            i_byte_data,
  output logic                  o_byte_ready,
  output logic                  o_wr_en,
  output logic [c_AW-1:0]       o_wr_addr,
  output logic [INST_WIDTH-1:0] o_wr_data,
  output logic                  o_cpu_hold,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_csum_err
);

  localparam int c_NBYTES = INST_WIDTH / 8;
  localparam int c_BIW    = (c_NBYTES > 1) ? $clog2(c_NBYTES) : 1;
  localparam logic [c_BIW-1:0] c_LAST_BYTE = c_BIW'(c_NBYTES - 1);
  localparam logic [c_AW:0]    c_MEM_SIZE  = (c_AW + 1)'(MEM_SIZE);
  localparam logic [c_AW:0]    c_ONE       = (c_AW + 1)'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
`ifdef LOADER_CSUM_EN
    S_CSUM = 2'd2,
`endif
    S_DONE = 2'd3
  } state_t;

  state_t                r_state;
  logic [c_BIW-1:0]      r_byte_idx;
  logic [c_AW-1:0]       r_word_idx;
  logic [c_AW-1:0]       r_last_idx;   // index of the final word (len-1)
  logic [INST_WIDTH-1:0] r_word;       // partially assembled word
  logic                  r_byte_ready;
  logic                  r_wr_en;
  logic [c_AW-1:0]       r_wr_addr;
  logic [INST_WIDTH-1:0] r_wr_data;
  logic                  r_busy;
  logic                  r_done;
`ifdef LOADER_CSUM_EN
  logic [INST_WIDTH-1:0] r_csum;       // running XOR of written words
  logic                  r_csum_err;
`endif

  logic                  w_xfer;
  logic                  w_last_byte;
  logic                  w_last_word;
  logic [c_AW:0]         w_len;
  logic [INST_WIDTH-1:0] w_word;

  // Handshake decode, clamped length and the word with the incoming byte merged in
  always_comb begin
    w_xfer      = i_byte_valid && r_byte_ready;
    w_last_byte = (r_byte_idx == c_LAST_BYTE);
    w_last_word = (r_word_idx == r_last_idx);
    w_len       = (i_num_words > c_MEM_SIZE) ? c_MEM_SIZE : i_num_words;
    w_word      = r_word;
    w_word[{r_byte_idx, 3'b000} +: 8] = i_byte_data;
  end

  // Loader FSM: all outputs are registered alongside the state transition
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_byte_idx   <= '0;
      r_word_idx   <= '0;
      r_last_idx   <= '0;
      r_word       <= '0;
      r_byte_ready <= 1'b0;
      r_wr_en      <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
`ifdef LOADER_CSUM_EN
      r_csum       <= '0;
      r_csum_err   <= 1'b0;
`endif
    end else begin
      // Write strobe is a single-cycle pulse unless re-armed below
      r_wr_en <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (i_start) begin
            r_byte_idx <= '0;
            r_word_idx <= '0;
            r_word     <= '0;
            r_last_idx <= c_AW'(w_len - c_ONE);
`ifdef LOADER_CSUM_EN
            r_csum     <= '0;
            r_csum_err <= 1'b0;
`endif
            if (w_len == '0) begin
              // Empty program: report completion without touching memory
              r_state      <= S_DONE;
              r_done       <= 1'b1;
              r_busy       <= 1'b0;
              r_byte_ready <= 1'b0;
            end else begin
              r_state      <= S_LOAD;
              r_done       <= 1'b0;
              r_busy       <= 1'b1;
              r_byte_ready <= 1'b1;
            end
          end
        end

        S_LOAD: begin
          if (w_xfer) begin
            r_word <= w_word;
            if (w_last_byte) begin
              r_byte_idx <= '0;
              r_wr_en    <= 1'b1;
              r_wr_addr  <= r_word_idx;
              r_wr_data  <= w_word;
`ifdef LOADER_CSUM_EN
              r_csum     <= r_csum ^ w_word;
`endif
              if (w_last_word) begin
`ifdef LOADER_CSUM_EN
                // Stay busy and ready: the checksum word follows
                r_state      <= S_CSUM;
`else
                r_state      <= S_DONE;
                r_done       <= 1'b1;
                r_busy       <= 1'b0;
                r_byte_ready <= 1'b0;
`endif
              end else begin
                r_word_idx <= r_word_idx + c_AW'(1);
              end
            end else begin
              r_byte_idx <= r_byte_idx + c_BIW'(1);
            end
          end
        end

`ifdef LOADER_CSUM_EN
        S_CSUM: begin
          if (w_xfer) begin
            r_word <= w_word;
            if (w_last_byte) begin
              r_byte_idx   <= '0;
              r_csum_err   <= (w_word != r_csum);
              r_state      <= S_DONE;
              r_done       <= 1'b1;
              r_busy       <= 1'b0;
              r_byte_ready <= 1'b0;
            end else begin
              r_byte_idx <= r_byte_idx + c_BIW'(1);
            end
          end
        end
`endif

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_byte_ready = r_byte_ready;
  assign o_wr_en      = r_wr_en;
  assign o_wr_addr    = r_wr_addr;
  assign o_wr_data    = r_wr_data;
  assign o_busy       = r_busy;
  assign o_cpu_hold   = r_busy;
  assign o_done       = r_done;
`ifdef LOADER_CSUM_EN
  assign o_csum_err   = r_csum_err;
`else
  assign o_csum_err   = 1'b0;
`endif

endmodule
`default_nettype wire
